// File: rtl/adc_spi_reader_pkg.sv
// Shared constants and FSM encoding for the ADC SPI read path.
// Defaults match the adc_trigger configuration docs.
package adc_pkg;

    localparam int ADC_BITS_DEF = 18;
    localparam int SCK_DIV_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        LOAD  = 2'd3
    } adc_state_e;

endpackage

// File: rtl/adc_spi_reader_if.sv
// AXI4-Stream beat bundle from the ADC reader to the DMA.
// Master drives data/valid/last, slave returns ready.
interface adc_spi_reader_if #(
    parameter int TDATA_WIDTH = 32
) ();
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/adc_spi_shift.sv
// SCK generator, bit counter and MSB-first shift register for one ADC read.
// start_i begins the low phase of bit 0; done_o pulses one cycle after the last high phase.
module adc_spi_shift
    import adc_pkg::*;
#(
    parameter int ADC_BITS = ADC_BITS_DEF,
    parameter int SCK_DIV  = SCK_DIV_DEF
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                start_i,
    input  logic                sdo_i,
    output logic                sck_o,
    output logic                done_o,
    output logic [ADC_BITS-1:0] data_o
);

    localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int BIT_W = (ADC_BITS > 1) ? $clog2(ADC_BITS) : 1;

    logic                active_q;
    logic                sck_q;
    logic                done_q;
    logic [DIV_W-1:0]    div_q;
    logic [BIT_W-1:0]    bit_q;
    logic [ADC_BITS-1:0] shreg_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            done_q   <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                active_q <= 1'b1;
                sck_q    <= 1'b0;
                div_q    <= '0;
                bit_q    <= '0;
            end else if (active_q) begin
                if (div_q == DIV_W'(SCK_DIV - 1)) begin
                    div_q <= '0;
                    if (!sck_q) begin
                        // sdo is stable here: the ADC only changes it after sck falls
                        sck_q   <= 1'b1;
                        shreg_q <= {shreg_q[ADC_BITS-2:0], sdo_i};
                    end else begin
                        sck_q <= 1'b0;
                        if (bit_q == BIT_W'(ADC_BITS - 1)) begin
                            active_q <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end
                end else begin
                    div_q <= div_q + DIV_W'(1);
                end
            end
        end
    end

    assign sck_o  = sck_q;
    assign done_o = done_q;
    assign data_o = shreg_q;

endmodule

// File: rtl/adc_spi_reader.sv
// Reads one ADC sample over SPI per trigger and emits it as a framed AXI4-Stream beat.
// Latency trigger->tvalid is 2+SCK_DIV*(1+2*ADC_BITS) cycles; single-entry output, overrun on drop.
module adc_spi_reader
    import adc_pkg::*;
#(
    parameter int ADC_BITS    = ADC_BITS_DEF,
    parameter int SCK_DIV     = SCK_DIV_DEF,
    parameter int TDATA_WIDTH = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 trigger,
    input  logic [CNT_WIDTH-1:0] packet_len,
    output logic                 cs_n,
    output logic                 sck,
    input  logic                 sdo,
    adc_spi_reader_if.master     m_axis,
    output logic                 last,
    output logic                 overrun,
    output logic                 rd_active
);

    localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

    adc_state_e             state_q;
    logic [DIV_W-1:0]       setup_cnt_q;
    logic                   cs_n_q;
    logic                   rd_active_q;
    logic                   tvalid_q;
    logic                   tlast_q;
    logic [TDATA_WIDTH-1:0] tdata_q;
    logic                   last_q;
    logic                   overrun_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   plen_q;

    logic                   shift_start;
    logic                   shift_done;
    logic [ADC_BITS-1:0]    shift_data;
    logic                   hs;
    logic                   load_ok;
    logic [CNT_WIDTH-1:0]   plen_d;
    logic [CNT_WIDTH-1:0]   cnt_d;
    logic                   tlast_d;

    adc_spi_shift #(
        .ADC_BITS (ADC_BITS),
        .SCK_DIV  (SCK_DIV)
    ) u_shift (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .start_i  (shift_start),
        .sdo_i    (sdo),
        .sck_o    (sck),
        .done_o   (shift_done),
        .data_o   (shift_data)
    );

    assign shift_start = (state_q == SETUP) && (setup_cnt_q == DIV_W'(SCK_DIV - 1));
    assign hs          = tvalid_q & m_axis.tready;
    assign load_ok     = !tvalid_q || hs;

    // packet_len is only sampled at the first beat of a packet
    always_comb begin
        plen_d = plen_q;
        if (cnt_q == '0) begin
            plen_d = (packet_len == '0) ? CNT_WIDTH'(1) : packet_len;
        end
        tlast_d = (cnt_q == plen_d - CNT_WIDTH'(1));
        cnt_d   = tlast_d ? '0 : cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            setup_cnt_q <= '0;
            cs_n_q      <= 1'b1;
            rd_active_q <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            last_q      <= 1'b0;
            overrun_q   <= 1'b0;
            cnt_q       <= '0;
            plen_q      <= CNT_WIDTH'(1);
        end else begin
            last_q <= hs & tlast_q;
            if (hs) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end
            if (trigger && state_q != IDLE) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        state_q     <= SETUP;
                        cs_n_q      <= 1'b0;
                        rd_active_q <= 1'b1;
                        setup_cnt_q <= '0;
                    end
                end
                SETUP: begin
                    if (shift_start) begin
                        state_q <= SHIFT;
                    end else begin
                        setup_cnt_q <= setup_cnt_q + DIV_W'(1);
                    end
                end
                SHIFT: begin
                    if (shift_done) begin
                        state_q <= LOAD;
                        cs_n_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    state_q     <= IDLE;
                    rd_active_q <= 1'b0;
                    // a beat leaving this cycle frees the slot for the new one
                    if (load_ok) begin
                        tvalid_q <= 1'b1;
                        tdata_q  <= TDATA_WIDTH'(shift_data);
                        tlast_q  <= tlast_d;
                        cnt_q    <= cnt_d;
                        plen_q   <= plen_d;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cs_n          = cs_n_q;
    assign rd_active     = rd_active_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tlast  = tlast_q;
    assign last          = last_q;
    assign overrun       = overrun_q;

endmodule
